// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution layers.
// Pure declarations: no latency, no flow control.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMPUTE = 2'd2
  } conv_state_t;

  // Bit width needed to index n items; never returns 0 so it is safe for port widths.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int out_dim(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int dw,
                                                  input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    if (relu && r[63]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines plus the KxK window; window updates in the same edge a pixel is shifted in.
// No internal flow control: contents move only while shift_en is high, otherwise frozen.
module conv_line_buffer #(
  parameter int IMG_W  = 28,
  parameter int K      = 3,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    shift_en,
  input  logic [DATA_W-1:0]       pix,
  output logic [K*K*DATA_W-1:0]   win
);

  // Each row delay plus the K window stages spans exactly one image row.
  localparam int D  = IMG_W - K;
  localparam int DD = (D > 0) ? D : 1;

  logic [DATA_W-1:0] wr   [K][K];
  logic [DATA_W-1:0] lb   [K-1][DD];
  logic [DATA_W-1:0] tail [K-1];

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      tail[r] = (D > 0) ? lb[r][DD-1] : wr[r+1][0];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          wr[r][c] <= '0;
      for (int r = 0; r < K - 1; r++)
        for (int i = 0; i < DD; i++)
          lb[r][i] <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          wr[r][c] <= wr[r][c+1];
      for (int r = 0; r < K - 1; r++)
        wr[r][K-1] <= tail[r];
      wr[K-1][K-1] <= pix;
      for (int r = 0; r < K - 1; r++) begin
        lb[r][0] <= wr[r+1][0];
        for (int i = 1; i < DD; i++)
          lb[r][i] <= lb[r][i-1];
      end
    end
  end

  // Row 0 is the oldest image row; tap index is r*K + c.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win[(r*K + c)*DATA_W +: DATA_W] = wr[r][c];
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK strided convolution, NUM_F filters per window, one result per out handshake.
// First result the cycle after the window-completing pixel; in_ready low while results drain.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int K         = 3,
  parameter int STRIDE    = 2,
  parameter int NUM_F     = 16,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1,
  localparam int AW       = clog2(NUM_F*K*K),
  localparam int FW       = clog2(NUM_F)
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     start,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [FW-1:0]            out_filt,
  output logic                     out_last,
  output logic                     busy
);

  localparam int TAPS  = K * K;
  localparam int RW    = clog2(IMG_W);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + clog2(TAPS);
  localparam int O     = out_dim(IMG_W, K, STRIDE);

  localparam logic [RW-1:0] LAST_RC  = RW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_WIN = RW'(K - 1 + (O - 1) * STRIDE);
  localparam logic [FW-1:0] LAST_F   = FW'(NUM_F - 1);

  conv_state_t state, state_nxt;

  logic [RW-1:0]   row, col;
  logic [FW-1:0]   f_idx;
  logic            pix_done, last_win;
  logic            accept, out_hs, win_hit, at_last;
  logic [TAPS*DATA_W-1:0] win_flat;

  logic signed [DATA_W-1:0] wts   [NUM_F][TAPS];
  logic signed [DATA_W-1:0] pix_a [TAPS];
  logic signed [DATA_W-1:0] w_a   [TAPS];
  logic signed [PW-1:0]     prod  [TAPS];
  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic signed [DATA_W-1:0] res;

  function automatic logic on_grid(input int p);
    return (p >= K - 1) && (((p - (K - 1)) % STRIDE) == 0);
  endfunction

  assign accept  = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign win_hit = on_grid(int'(row)) && on_grid(int'(col));
  assign at_last = (row == LAST_RC) && (col == LAST_RC);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (win_hit)      state_nxt = COMPUTE;
          else if (at_last) state_nxt = IDLE;
        end
      end
      COMPUTE: begin
        out_valid = 1'b1;
        if (out_ready && (f_idx == LAST_F))
          state_nxt = pix_done ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the pixel about to be accepted; the window it completes is judged before advancing.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      row      <= '0;
      col      <= '0;
      f_idx    <= '0;
      pix_done <= 1'b0;
      last_win <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        row      <= '0;
        col      <= '0;
        f_idx    <= '0;
        pix_done <= 1'b0;
        last_win <= 1'b0;
      end
      if (accept) begin
        if (col == LAST_RC) begin
          col <= '0;
          row <= (row == LAST_RC) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (at_last) pix_done <= 1'b1;
        if (win_hit) begin
          f_idx    <= '0;
          last_win <= (row == LAST_WIN) && (col == LAST_WIN);
        end
      end
      if (out_hs) f_idx <= (f_idx == LAST_F) ? '0 : f_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int f = 0; f < NUM_F; f++)
        for (int t = 0; t < TAPS; t++)
          wts[f][t] <= '0;
    end else if ((state == IDLE) && wr_en) begin
      for (int f = 0; f < NUM_F; f++)
        for (int t = 0; t < TAPS; t++)
          if (wr_addr == AW'(f*TAPS + t)) wts[f][t] <= wr_data;
    end
  end

  conv_line_buffer #(
    .IMG_W  (IMG_W),
    .K      (K),
    .DATA_W (DATA_W)
  ) u_line_buffer (
    .clk      (clk),
    .rstb     (rstb),
    .shift_en (accept),
    .pix      (in_data),
    .win      (win_flat)
  );

  // Window and filter index are frozen during COMPUTE, so the result holds under stall.
  always_comb begin
    acc = '0;
    for (int t = 0; t < TAPS; t++) begin
      pix_a[t] = win_flat[t*DATA_W +: DATA_W];
      w_a[t]   = wts[f_idx][t];
      prod[t]  = PW'(pix_a[t]) * PW'(w_a[t]);
      acc      = acc + ACC_W'(prod[t]);
    end
    acc_sh = acc >>> FRAC_BITS;
    res    = DATA_W'(sat_relu(64'(acc_sh), DATA_W, RELU != 0));
  end

  assign out_data = out_valid ? res : '0;
  assign out_filt = out_valid ? f_idx : '0;
  assign out_last = out_valid && last_win && (f_idx == LAST_F);

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: stride-2 ReLU instance (a) and stride-1 linear instance (b).
module tb_conv_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb, start, wr_en, in_valid, out_ready, sel;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data, in_data;

  logic rdy_a, ov_a, ol_a, busy_a, of_a;
  logic rdy_b, ov_b, ol_b, busy_b, of_b;
  logic [15:0] od_a, od_b;

  logic in_ready_m, ov_m, ol_m, busy_m, of_m;
  logic [15:0] od_m;
  assign in_ready_m = sel ? rdy_b  : rdy_a;
  assign ov_m       = sel ? ov_b   : ov_a;
  assign ol_m       = sel ? ol_b   : ol_a;
  assign busy_m     = sel ? busy_b : busy_a;
  assign of_m       = sel ? of_b   : of_a;
  assign od_m       = sel ? od_b   : od_a;

  conv_stream_engine #(.IMG_W(5), .K(3), .STRIDE(2), .NUM_F(2), .DATA_W(16), .FRAC_BITS(8), .RELU(1)) dut_a (
    .clk(clk), .rstb(rstb), .start(start & ~sel), .wr_en(wr_en & ~sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_filt(of_a),
    .out_last(ol_a), .busy(busy_a));

  conv_stream_engine #(.IMG_W(5), .K(3), .STRIDE(1), .NUM_F(2), .DATA_W(16), .FRAC_BITS(8), .RELU(0)) dut_b (
    .clk(clk), .rstb(rstb), .start(start & sel), .wr_en(wr_en & sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_filt(of_b),
    .out_last(ol_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  logic [15:0] pix_q [$];
  logic [15:0] got_d [$];
  logic        got_f [$];
  logic        got_l [$];
  int first_cyc, frame_cyc, stab_err, rdy_err;
  bit timed_out, start_rdy, start_busy;

  task automatic load_w(input int addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_pix(input logic [15:0] v);
    pix_q.delete();
    for (int i = 0; i < 25; i++) pix_q.push_back(v);
  endtask

  // Drives one frame into the selected instance and collects every handed-off result.
  task automatic run_frame(input int vmode, input int rmode, input bit inj);
    int pi, cyc;
    bit stall, inj_f, inj_c;
    logic [15:0] pd;
    logic pf, pl;
    got_d.delete(); got_f.delete(); got_l.delete();
    first_cyc = -1; stab_err = 0; rdy_err = 0;
    pi = 0; cyc = 0; stall = 0; inj_f = 0; inj_c = 0; pd = '0; pf = 0; pl = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    start_rdy  = in_ready_m;
    start_busy = busy_m;
    while (busy_m && cyc < 3000) begin
      if (ov_m && first_cyc < 0) first_cyc = cyc;
      if (ov_m && in_ready_m) rdy_err++;
      if (stall && (!ov_m || od_m !== pd || of_m !== pf || ol_m !== pl)) stab_err++;
      start = 1'b0; wr_en = 1'b0;
      out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = 1'b0; in_data = '0;
      if (pi < pix_q.size() && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1; in_data = pix_q[pi];
      end
      if (inj && ((!inj_f && pi == 7) || (!inj_c && ov_m))) begin
        if (pi == 7) inj_f = 1;
        if (ov_m) inj_c = 1;
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 16'h1234;
      end
      if (in_valid && in_ready_m) pi++;
      if (ov_m && out_ready) begin
        got_d.push_back(od_m); got_f.push_back(of_m); got_l.push_back(ol_m);
      end
      stall = ov_m && !out_ready; pd = od_m; pf = of_m; pl = ol_m;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    frame_cyc = cyc;
    timed_out = (cyc >= 3000);
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    if ({ov_a, rdy_a, busy_a, of_a, ol_a} !== 5'b0) begin bad++; $display("FAIL reset_ctl_a got %b want 00000", {ov_a, rdy_a, busy_a, of_a, ol_a}); end
    total++;
    if (od_a !== 16'h0) begin bad++; $display("FAIL reset_data_a got %h want 0000", od_a); end
    total++;
    if ({ov_b, rdy_b, busy_b, of_b, ol_b} !== 5'b0 || od_b !== 16'h0) begin bad++; $display("FAIL reset_b got %b/%h want 0", {ov_b, rdy_b, busy_b, of_b, ol_b}, od_b); end
    total++;
    rstb = 1'b1;
    @(negedge clk);
    if ({ov_a, rdy_a, busy_a} !== 3'b0) begin bad++; $display("FAIL idle_after_reset got %b want 000", {ov_a, rdy_a, busy_a}); end
    total++;
  endtask

  // Shared expectation for the all-ones frame on instance a with W0=1.0, W1=0.
  task automatic check_ones(input string tag);
    if (timed_out || got_d.size() != 8) begin bad++; $display("FAIL %s_count got %0d want 8 (timeout=%0d)", tag, got_d.size(), timed_out); end
    total++;
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      if (got_d[i] !== ((i % 2 == 0) ? 16'd2304 : 16'd0) || got_f[i] !== 1'(i % 2) || got_l[i] !== (i == 7)) begin
        bad++; $display("FAIL %s_res[%0d] got d=%0d f=%0d l=%0d want d=%0d f=%0d l=%0d", tag, i, got_d[i], got_f[i], got_l[i], (i % 2 == 0) ? 2304 : 0, i % 2, i == 7);
      end
      total++;
    end
  endtask

  task automatic test_ones;
    sel = 1'b0;
    for (int t = 0; t < 9; t++) load_w(t, 16'h0100);
    fill_pix(16'h0100);
    run_frame(0, 0, 0);
    if (!start_rdy || !start_busy) begin bad++; $display("FAIL start_timing got rdy=%0d busy=%0d want 1 1", start_rdy, start_busy); end
    total++;
    if (first_cyc != 13) begin bad++; $display("FAIL first_latency got %0d want 13", first_cyc); end
    total++;
    if (frame_cyc != 33) begin bad++; $display("FAIL frame_cycles got %0d want 33", frame_cyc); end
    total++;
    check_ones("ones");
  endtask

  task automatic test_identity(input int vmode, input int rmode);
    logic [15:0] v;
    sel = 1'b1;
    if (vmode == 0) begin
      load_w(4, 16'h0100);
      load_w(13, 16'hFF00);
    end
    pix_q.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) pix_q.push_back(16'((r*5 + c) << 8));
    run_frame(vmode, rmode, 0);
    if (timed_out || got_d.size() != 18) begin bad++; $display("FAIL ident%0d_count got %0d want 18", rmode, got_d.size()); end
    total++;
    for (int k = 0; k < 9 && 2*k + 1 < got_d.size(); k++) begin
      v = 16'((((k/3) + 1)*5 + (k%3) + 1) << 8);
      if (got_d[2*k] !== v || got_d[2*k+1] !== 16'(-v) || got_f[2*k] !== 1'b0 || got_f[2*k+1] !== 1'b1) begin
        bad++; $display("FAIL ident%0d_win[%0d] got %0d,%0d want %0d,%0d", rmode, k, $signed(got_d[2*k]), $signed(got_d[2*k+1]), $signed(v), -$signed(v));
      end
      total++;
      if (got_l[2*k+1] !== (k == 8) || got_l[2*k] !== 1'b0) begin bad++; $display("FAIL ident%0d_last[%0d] got %0d%0d want %0d", rmode, k, got_l[2*k], got_l[2*k+1], k == 8); end
      total++;
    end
    if (rmode != 0) begin
      if (stab_err != 0) begin bad++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
      total++;
      if (rdy_err != 0) begin bad++; $display("FAIL ready_in_compute got %0d want 0", rdy_err); end
      total++;
    end
  endtask

  task automatic test_busy_ignore;
    sel = 1'b0;
    fill_pix(16'h0100);
    run_frame(0, 0, 1);
    if (frame_cyc != 33) begin bad++; $display("FAIL ignore_cycles got %0d want 33", frame_cyc); end
    total++;
    check_ones("ignore");
  endtask

  task automatic test_saturation(input bit s, input logic [15:0] neg_exp);
    sel = s;
    for (int t = 0; t < 9; t++) begin
      load_w(t, 16'h7FFF);
      load_w(9 + t, 16'h8001);
    end
    fill_pix(16'h7FFF);
    run_frame(0, 0, 0);
    if (timed_out || got_d.size() != (s ? 18 : 8)) begin bad++; $display("FAIL sat%0d_count got %0d want %0d", s, got_d.size(), s ? 18 : 8); end
    total++;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== ((i % 2 == 0) ? 16'h7FFF : neg_exp)) begin
        bad++; $display("FAIL sat%0d_res[%0d] got %h want %h", s, i, got_d[i], (i % 2 == 0) ? 16'h7FFF : neg_exp);
      end
      total++;
    end
  endtask

  task automatic test_midreset;
    int c;
    sel = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b0;
    c = 0;
    while (!ov_m && c < 100) begin @(negedge clk); c++; end
    in_valid = 1'b0;
    if (!ov_m || in_ready_m) begin bad++; $display("FAIL midreset_reach got valid=%0d rdy=%0d want 1 0", ov_m, in_ready_m); end
    total++;
    rstb = 1'b0;
    #1;
    if ({ov_a, rdy_a, busy_a, of_a, ol_a} !== 5'b0 || od_a !== 16'h0) begin
      bad++; $display("FAIL midreset_out got %b/%h want 00000/0000", {ov_a, rdy_a, busy_a, of_a, ol_a}, od_a);
    end
    total++;
    @(negedge clk); rstb = 1'b1;
    fill_pix(16'h0100);
    run_frame(0, 0, 0);
    if (got_d.size() != 8) begin bad++; $display("FAIL cleared_count got %0d want 8", got_d.size()); end
    total++;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== 16'h0) begin bad++; $display("FAIL cleared_w[%0d] got %h want 0000", i, got_d[i]); end
      total++;
    end
    for (int t = 0; t < 9; t++) load_w(t, 16'h0100);
    run_frame(0, 0, 0);
    check_ones("reload");
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0;
    test_reset();
    test_ones();
    test_identity(0, 0);
    test_identity(1, 1);
    test_busy_ignore();
    test_saturation(1'b0, 16'h0000);
    test_saturation(1'b1, 16'h8000);
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Streaming, parametrised successor to the combinational convolution layer. It accepts an image one pixel per handshake in raster order and buffers K-1 rows internally. For every valid stride-aligned K×K window it produces NUM_F fixed-point outputs, one filter per cycle, with saturation and optional ReLU. It sits between the pixel source and the next CNN layer inside `cnn`, and uses valid/ready on both sides.

## Interface
- IMG_W, 28: square image side, in pixels.
- K, 3: filter side, K×K taps.
- STRIDE, 2: window step, horizontal and vertical.
- NUM_F, 16: number of filters.
- DATA_W, 16: signed pixel, weight and output width.
- FRAC_BITS, 8: fractional bits of the fixed-point format.
- RELU, 1: 1 clamps negative results to 0.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- wr_en  in  1  weight write strobe; honoured only in IDLE.
- wr_addr  in  clog2(NUM_F*K*K)  weight address = f*K*K + r*K + c.
- wr_data  in  DATA_W  signed weight.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  DATA_W  signed pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DATA_W  signed result.
- out_filt  out  clog2(NUM_F)  filter index of out_data.
- out_last  out  1  marks the final result of the frame.
- busy  out  1  high from start until the frame fully completes.

## Operation
- FSM states are IDLE, FILL, COMPUTE.
- IDLE:
  - Weight writes are performed here.
  - start clears the row/col counters and moves to FILL.
  - If wr_en and start occur in the same cycle, the write is performed and the start is taken.
- FILL:
  - in_ready=1.
  - Each accepted pixel shifts into the line buffer/window and advances col, then row.
  - The window is valid when row≥K-1, col≥K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0. When the pixel just accepted completes a valid window, go to COMPUTE.
  - Pixels that complete no window, including trailing columns and rows, are accepted and discarded.
  - When the pixel at (IMG_W-1, IMG_W-1) is accepted and it completes no window, go to IDLE.
- COMPUTE:
  - in_ready=0 and the window is frozen.
  - For f=0..NUM_F-1: out_data = conv(window, W[f]), out_filt=f.
  - f advances only on the out handshake.
  - After f=NUM_F-1 is accepted, go to FILL. If the frame's pixels are already exhausted, go to IDLE instead.
- Arithmetic:
  - Products are signed, 2*DATA_W wide.
  - The accumulator is 2*DATA_W+clog2(K*K) wide, so it cannot overflow.
  - Result = sum >>> FRAC_BITS (arithmetic shift, truncation), then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then clamped to 0 if RELU and negative.
- Outputs per frame = O*O*NUM_F, with O=(IMG_W-K)/STRIDE+1. The default is 13*13*16=2704.
- out_last=1 on filter NUM_F-1 of window (O-1, O-1).
- start, wr_en while busy: ignored; weights are unchanged.
- out_ready low: out_valid, out_data, out_filt and out_last hold stable until the handshake.

## Timing
- Reset values: FSM=IDLE, all weights 0, counters 0, in_ready=0, out_valid=0, out_data=0, out_filt=0, out_last=0, busy=0.
- start → FILL and in_ready=1 on the next cycle; busy=1 from the cycle after start.
- Latency: the first out_valid appears in the cycle after the window-completing pixel is accepted. in_ready drops in that same cycle.
- With out_ready held at 1, one result per cycle. in_ready returns in the cycle after the filter NUM_F-1 handshake.
- busy falls in the cycle after the final pixel is accepted or the final result is handed off, whichever is later.
- Reset asserted mid-frame: every register returns to its reset value immediately; a partial frame is lost.

## Structure
- Package conv_pkg holds the following, shared with `cnn` and later layers:
  - clog2 function.
  - out_dim(IMG_W,K,STRIDE) function.
  - sat_relu function.
  - FSM state enum.
- Sub-module conv_line_buffer contains:
  - K-1 row shift registers of IMG_W-… depth.
  - The K×K window register array.
  - Ports: shift enable, pixel in, window out.
- The top module contains the FSM, counters, weight register file, the K*K-multiplier MAC tree and the output register.

## Test plan
- IMG_W=5,K=3,STRIDE=2,NUM_F=2: all pixels 256 (1.0), W[0] all 256, W[1] all 0 → 8 results, alternating f0=2304 and f1=0; out_last only on the 8th.
- Identity kernel (centre tap 256), STRIDE=1, pixel(r,c)=(r*5+c)<<8 → result(i,j)=((i+1)*5+j+1)<<8; 9 results.
- Pixels 0x7FFF, weights 0x7FFF → 32767. Weights 0x8001 with RELU=1 → 0; with RELU=0 → -32768.
- Random out_ready at 50% and bursty in_valid → identical result sequence. Outputs stay stable while stalled, and in_ready=0 throughout COMPUTE.
- wr_en and start pulsed mid-frame → no effect on weights or results.
- rstb asserted mid-frame → all outputs 0 and weights 0 next cycle. Reload weights and start → correct full frame.
